// File: rtl/merge_arbiter_sync.sv
// merge_arbiter_sync: two-input packet merge with per-input holding slots, RR/priority grant and saturating delivery counters
//   CLK, MR                      clock, synchronous active-high reset
//   Send_in_EX/IN, PACKET_IN_*   producer valid level and packet
//   Ack_out_EX/IN                one-cycle capture acknowledge
//   Send_out, PACKET_OUT, SRC_OUT merged output (held until Ack_in), source 0=EX 1=IN
//   Ack_in                       downstream accept
//   CNT_EX, CNT_IN               saturating delivered-packet counters
module merge_arbiter_sync #(
    parameter int WIDTH         = 38,
    parameter int PRIORITY_MODE = 0,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             Send_in_EX,
    input  logic [WIDTH-1:0] PACKET_IN_EXTERNAL,
    output logic             Ack_out_EX,
    input  logic             Send_in_IN,
    input  logic [WIDTH-1:0] PACKET_IN_INTERNAL,
    output logic             Ack_out_IN,
    output logic             Send_out,
    output logic [WIDTH-1:0] PACKET_OUT,
    input  logic             Ack_in,
    output logic             SRC_OUT,
    output logic [CNT_W-1:0] CNT_EX,
    output logic [CNT_W-1:0] CNT_IN
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] slot_ex, slot_in;
    logic             full_ex, full_in, last_in;
    logic             cap_ex, cap_in, gnt_in, load, done;

    // The Ack cycle blocks recapture of a still-asserted Send level
    assign cap_ex   = Send_in_EX && !full_ex && !Ack_out_EX;
    assign cap_in   = Send_in_IN && !full_in && !Ack_out_IN;
    assign done     = (state == SEND) && Ack_in;
    assign load     = (full_ex || full_in) && ((state == IDLE) || Ack_in);
    // On a tie IN wins in priority mode, otherwise whoever was not granted last
    assign gnt_in   = full_in && (!full_ex || (PRIORITY_MODE != 0) || !last_in);
    assign Send_out = (state == SEND);

    always_ff @(posedge CLK) begin
        if (MR) begin
            state      <= IDLE;
            slot_ex    <= '0;
            slot_in    <= '0;
            full_ex    <= 1'b0;
            full_in    <= 1'b0;
            last_in    <= 1'b1;
            Ack_out_EX <= 1'b0;
            Ack_out_IN <= 1'b0;
            PACKET_OUT <= '0;
            SRC_OUT    <= 1'b0;
            CNT_EX     <= '0;
            CNT_IN     <= '0;
        end else begin
            Ack_out_EX <= cap_ex;
            Ack_out_IN <= cap_in;
            if (cap_ex) begin
                slot_ex <= PACKET_IN_EXTERNAL;
                full_ex <= 1'b1;
            end else if (load && !gnt_in) begin
                full_ex <= 1'b0;
            end
            if (cap_in) begin
                slot_in <= PACKET_IN_INTERNAL;
                full_in <= 1'b1;
            end else if (load && gnt_in) begin
                full_in <= 1'b0;
            end
            if (done && !SRC_OUT)
                CNT_EX <= (CNT_EX == '1) ? CNT_EX : CNT_EX + 1'b1;
            if (done && SRC_OUT)
                CNT_IN <= (CNT_IN == '1) ? CNT_IN : CNT_IN + 1'b1;
            if (load) begin
                PACKET_OUT <= gnt_in ? slot_in : slot_ex;
                SRC_OUT    <= gnt_in;
                last_in    <= gnt_in;
                state      <= SEND;
            end else if (done) begin
                state      <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_merge_arbiter_sync.sv
// tb_merge_arbiter_sync: directed self-checking bench for merge_arbiter_sync
module tb_merge_arbiter_sync;
    logic        CLK = 1'b0;
    logic        MR = 1'b1;
    logic        Send_in_EX = 1'b0, Send_in_IN = 1'b0, Ack_in = 1'b0;
    logic [37:0] PACKET_IN_EXTERNAL = '0, PACKET_IN_INTERNAL = '0;
    logic        Ack_out_EX, Ack_out_IN, Send_out, SRC_OUT;
    logic [37:0] PACKET_OUT;
    logic [15:0] CNT_EX, CNT_IN;
    logic        ack_ex2, ack_in2, send2, src2;
    logic [37:0] pkt2;
    logic [3:0]  cnt_ex2, cnt_in2;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    merge_arbiter_sync dut (
        .CLK(CLK), .MR(MR),
        .Send_in_EX(Send_in_EX), .PACKET_IN_EXTERNAL(PACKET_IN_EXTERNAL), .Ack_out_EX(Ack_out_EX),
        .Send_in_IN(Send_in_IN), .PACKET_IN_INTERNAL(PACKET_IN_INTERNAL), .Ack_out_IN(Ack_out_IN),
        .Send_out(Send_out), .PACKET_OUT(PACKET_OUT), .Ack_in(Ack_in), .SRC_OUT(SRC_OUT),
        .CNT_EX(CNT_EX), .CNT_IN(CNT_IN)
    );

    merge_arbiter_sync #(.WIDTH(38), .PRIORITY_MODE(1), .CNT_W(4)) dut2 (
        .CLK(CLK), .MR(MR),
        .Send_in_EX(Send_in_EX), .PACKET_IN_EXTERNAL(PACKET_IN_EXTERNAL), .Ack_out_EX(ack_ex2),
        .Send_in_IN(Send_in_IN), .PACKET_IN_INTERNAL(PACKET_IN_INTERNAL), .Ack_out_IN(ack_in2),
        .Send_out(send2), .PACKET_OUT(pkt2), .Ack_in(Ack_in), .SRC_OUT(src2),
        .CNT_EX(cnt_ex2), .CNT_IN(cnt_in2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        MR = 1'b1;
        tick();
        MR = 1'b0;
    endtask

    initial begin
        // single EX packet
        do_reset();
        check("rst_outs", {Send_out, Ack_out_EX, Ack_out_IN, SRC_OUT, PACKET_OUT}, '0);
        check("rst_cnts", {CNT_EX, CNT_IN, cnt_ex2, cnt_in2}, '0);
        Send_in_EX = 1'b1;
        PACKET_IN_EXTERNAL = 38'h12_3456_789A;
        tick();
        check("cap_ack", {Ack_out_EX, Ack_out_IN, Send_out}, 3'b100);
        Send_in_EX = 1'b0;
        tick();
        check("issue", {Ack_out_EX, Send_out, SRC_OUT, PACKET_OUT}, {3'b010, 38'h12_3456_789A});
        Ack_in = 1'b1;
        tick();
        Ack_in = 1'b0;
        check("deliver", {Send_out, CNT_EX, CNT_IN}, {1'b0, 16'd1, 16'd0});
        check("pkt_keep", PACKET_OUT, 38'h12_3456_789A);

        // tie: round-robin EX first, priority instance IN first
        do_reset();
        Send_in_EX = 1'b1; PACKET_IN_EXTERNAL = 38'h1;
        Send_in_IN = 1'b1; PACKET_IN_INTERNAL = 38'h2;
        Ack_in = 1'b1;
        tick();
        check("tie_acks", {Ack_out_EX, Ack_out_IN}, 2'b11);
        Send_in_EX = 1'b0; Send_in_IN = 1'b0;
        tick();
        check("rr_first", {Send_out, SRC_OUT, PACKET_OUT}, {2'b10, 38'h1});
        check("pm_first", {send2, src2, pkt2}, {2'b11, 38'h2});
        tick();
        check("rr_second", {Send_out, SRC_OUT, PACKET_OUT, CNT_EX}, {2'b11, 38'h2, 16'd1});
        tick();
        check("rr_done", {Send_out, CNT_EX, CNT_IN}, {1'b0, 16'd1, 16'd1});

        // priority mode under continuous traffic: IN, EX alternate, EX only while IN slot refills
        do_reset();
        Send_in_EX = 1'b1; PACKET_IN_EXTERNAL = 38'hE;
        Send_in_IN = 1'b1; PACKET_IN_INTERNAL = 38'hF;
        Ack_in = 1'b1;
        tick();
        for (int k = 2; k <= 9; k++) begin
            tick();
            check("pm_seq", {send2, src2, pkt2}, (k % 2 == 0) ? {2'b11, 38'hF} : {2'b10, 38'hE});
        end
        Send_in_EX = 1'b0; Send_in_IN = 1'b0;
        tick(); tick(); tick(); tick();
        check("pm_cnts", {cnt_ex2, cnt_in2, send2}, {4'd4, 4'd5, 1'b0});

        // downstream stall: output frozen, no acks once both slots are full
        do_reset();
        Ack_in = 1'b0;
        Send_in_EX = 1'b1; PACKET_IN_EXTERNAL = 38'hAA;
        Send_in_IN = 1'b1; PACKET_IN_INTERNAL = 38'hBB;
        tick(); tick(); tick(); tick();
        for (int k = 0; k < 20; k++) begin
            check("stall", {Send_out, SRC_OUT, Ack_out_EX, Ack_out_IN, PACKET_OUT}, {4'b1000, 38'hAA});
            tick();
        end

        // reset mid-SEND drops held packets
        Send_in_IN = 1'b0;
        PACKET_IN_EXTERNAL = 38'h55;
        do_reset();
        check("mr_outs", {Send_out, Ack_out_EX, Ack_out_IN, SRC_OUT, PACKET_OUT}, '0);
        check("mr_cnts", {CNT_EX, CNT_IN}, '0);
        tick();
        Send_in_EX = 1'b0;
        tick();
        check("mr_new", {Send_out, SRC_OUT, PACKET_OUT}, {2'b10, 38'h55});
        Ack_in = 1'b1;
        tick();
        check("mr_drained", {Send_out, CNT_EX, CNT_IN}, {1'b0, 16'd1, 16'd0});
        tick();
        check("mr_no_old", Send_out, 1'b0);

        // 17 EX deliveries: 4-bit counter saturates, 16-bit one counts on
        Ack_in = 1'b0;
        do_reset();
        Ack_in = 1'b1;
        Send_in_EX = 1'b1; PACKET_IN_EXTERNAL = 38'h3;
        for (int k = 0; k < 33; k++) tick();
        Send_in_EX = 1'b0;
        tick(); tick(); tick();
        check("sat4", cnt_ex2, 4'd15);
        check("cnt16", {CNT_EX, CNT_IN, Send_out}, {16'd17, 16'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/merge_arbiter_sync.md
Name: merge_arbiter_sync

Overview:
- Synchronous two-input packet merge controller for the DDP ring.
- Arbitrates between the external packet stream (EX) and the internal circulation stream (IN), and drives one merged output with a Send/Ack handshake.
- Each input has a one-entry holding register. A round-robin or fixed-priority grant selects which held packet is issued downstream.
- Per-source delivered-packet counters support throughput debug.

Parameters:
- WIDTH, 38: packet width in bits.
- PRIORITY_MODE, 0: 0 = round-robin on ties; 1 = IN always wins ties.
- CNT_W, 16: width of the delivered-packet counters.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- MR  in  1  reset, synchronous, active-high.
- Send_in_EX  in  1  external producer has a valid packet (level).
- PACKET_IN_EXTERNAL  in  WIDTH  external packet, stable while Send_in_EX=1.
- Ack_out_EX  out  1  one-cycle pulse: external packet captured.
- Send_in_IN  in  1  internal producer has a valid packet (level).
- PACKET_IN_INTERNAL  in  WIDTH  internal packet, stable while Send_in_IN=1.
- Ack_out_IN  out  1  one-cycle pulse: internal packet captured.
- Send_out  out  1  merged packet valid (level, held until acknowledged).
- PACKET_OUT  out  WIDTH  merged packet (registered).
- Ack_in  in  1  downstream accepted PACKET_OUT (sampled at the clock edge).
- SRC_OUT  out  1  source of the current PACKET_OUT: 0 = EX, 1 = IN.
- CNT_EX  out  CNT_W  packets from EX delivered downstream (saturating).
- CNT_IN  out  CNT_W  packets from IN delivered downstream (saturating).

Behaviour:
- Reset: MR=1 at an edge clears everything, whatever operation is in flight:
  - Send_out, Ack_out_EX, Ack_out_IN, SRC_OUT = 0.
  - PACKET_OUT = 0; both holding registers and their full flags = 0.
  - CNT_EX, CNT_IN = 0.
  - FSM = IDLE; last-grant pointer = IN, so EX wins the first tie.
  - Packets held at reset are dropped.
- Capture (per input X):
  - Condition: Send_in_X=1, slot X empty, and Ack_out_X=0 at the edge.
  - Action: hold PACKET_IN_X in slot X, set full_X, and assert Ack_out_X=1 for exactly the following cycle.
  - The producer drops Send_in_X or changes the packet in that Ack cycle. Send_in_X still high during the Ack cycle is not captured again.
  - A slot freed at an edge cannot capture at that same edge, so max input rate is one packet per 2 cycles per source.
- Grant:
  - Only EX full -> EX. Only IN full -> IN.
  - Both full, PRIORITY_MODE=1 -> IN.
  - Both full, PRIORITY_MODE=0 -> the source not equal to the last-grant pointer.
  - The pointer updates on every grant.
- FSM IDLE:
  - Send_out=0; Ack_in is ignored.
  - If any slot is full: load the granted packet into PACKET_OUT, set SRC_OUT, clear that slot's full flag, Send_out=1, go to SEND.
- FSM SEND:
  - Send_out=1; PACKET_OUT and SRC_OUT stay stable until Ack_in=1.
  - On Ack_in=1: increment the counter for SRC_OUT, saturating at all-ones.
  - Then, if any slot is full: load the next grant at that same edge, keep Send_out=1, stay in SEND (back-to-back issue).
  - Otherwise: Send_out=0, go to IDLE; PACKET_OUT keeps its last value.
- Latency: from a capture edge to Send_out=1 is 1 edge, provided the FSM is IDLE.
- Simultaneous events: a capture into slot X and a grant of slot Y≠X at the same edge are independent and both occur.
- Arithmetic: the packet is passed through unmodified; counters are unsigned and saturating, never wrapping.

Test Plan:
- Reset, then Send_in_EX=1 with packet 0x12_3456_789A held: Ack_out_EX pulses 1 cycle after capture. Send_out=1 the edge after capture with PACKET_OUT=0x123456789A, SRC_OUT=0. Ack_in=1 -> Send_out=0, CNT_EX=1.
- Both inputs present together, PRIORITY_MODE=0, EX=0x1, IN=0x2, Ack_in tied 1: output order EX(0x1) then IN(0x2) back-to-back with Send_out continuously 1. Then CNT_EX=1, CNT_IN=1.
- PRIORITY_MODE=1, both inputs continuously sending, Ack_in held 1: every tie goes to IN. EX is issued only in cycles when slot IN is empty.
- Ack_in held 0 for 20 cycles while in SEND: PACKET_OUT and SRC_OUT stay unchanged, and no further Ack_out pulses occur once both slots are full.
- MR asserted mid-SEND with both slots full: next cycle all outputs and counters are 0 and FSM is IDLE. After MR drops, the first issued packet is the one newly presented.
- CNT_W=4, 17 EX packets delivered: CNT_EX saturates at 15.
